ttfs_tinyodin_charge: RTL and testbench

TTFS_TINYODIN_CHARGE -- requirements
Module: ttfs_tinyodin_charge

---
 rtl/obi_pkg.sv | 18 +
 rtl/tinyodin_pkg.sv | 51 +++++
 rtl/tinyodin_neuron_update.sv | 30 +++
 rtl/ttfs_tinyodin_charge.sv | 222 ++++++++++++++++++++++
 tb/tb_ttfs_tinyodin_charge.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/obi_pkg.sv
// Minimal OBI request/response structs used as the default bus types of the charge block.
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/tinyodin_pkg.sv
// Shared constants, field layout and FSM states for the tinyODIN time-to-first-spike core.
package tinyodin_pkg;

  localparam int REGION_LSB = 20;
  localparam int REGION_W   = 2;
  localparam logic [1:0] REGION_SPIKE   = 2'b00;
  localparam logic [1:0] REGION_NEURON  = 2'b01;
  localparam logic [1:0] REGION_SYNAPSE = 2'b10;
  localparam logic [1:0] REGION_CTRL    = 2'b11;

  localparam int SPIKE_WORDS  = 64;
  localparam int NEURON_WORDS = 256;
  localparam int SYN_WORDS    = 8192;

  localparam int V_LSB  = 0;
  localparam int V_W    = 12;
  localparam int TH_LSB = 12;
  localparam int TH_W   = 12;
  localparam int F_BIT  = 24;
  localparam int W_W    = 4;
  localparam logic [31:0] NEURON_MASK = 32'h01FF_FFFF;

  localparam int CTRL_T_LSB     = 24;
  localparam int CTRL_T_W       = 8;
  localparam int CTRL_START_BIT = 10;
  localparam int CTRL_BUSY_BIT  = 1;
  localparam int CTRL_DONE_BIT  = 0;

  localparam logic [7:0] SPIKE_NONE = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    SYN_RD,
    NEUR_UPD,
    FIRE,
    DONE
  } state_t;

  function automatic logic [31:0] pack_neuron(input logic [V_W-1:0] v,
                                              input logic [TH_W-1:0] th,
                                              input logic f);
    return {7'b0, f, th, v};
  endfunction

  // Four spike times share one word; entry k lives in byte k%4.
  function automatic logic [7:0] spike_byte(input logic [31:0] w, input logic [1:0] sel);
    return w[{sel, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/tinyodin_neuron_update.sv
// Combinational potential update: add a signed 4-bit weight, then compare against threshold.
// Defining TTFS_SATURATE_EN clamps the sum to the 12-bit signed range instead of wrapping.
module tinyodin_neuron_update
  import tinyodin_pkg::*;
(
  input  logic [V_W-1:0]  v,
  input  logic [W_W-1:0]  weight,
  input  logic [TH_W-1:0] th,
  output logic [V_W-1:0]  v_next,
  output logic            above
);

  logic [V_W:0] sum;

  // One guard bit makes overflow visible as a mismatch between the top two sum bits.
  always_comb begin
    sum = {v[V_W-1], v} + {{(V_W + 1 - W_W){weight[W_W-1]}}, weight};
`ifdef TTFS_SATURATE_EN
    if (sum[V_W] != sum[V_W-1]) begin
      v_next = sum[V_W] ? {1'b1, {(V_W-1){1'b0}}} : {1'b0, {(V_W-1){1'b1}}};
    end else begin
      v_next = sum[V_W-1:0];
    end
`else
    v_next = sum[V_W-1:0];
`endif
    above = $signed({v_next[V_W-1], v_next}) >= $signed({1'b0, th});
  end

endmodule

// File: rtl/ttfs_tinyodin_charge.sv
// OBI-mapped time-to-first-spike charge engine: spike/neuron/synapse memories plus the run FSM.
// Optional macro TTFS_SATURATE_EN selects saturating potential arithmetic.
module ttfs_tinyodin_charge
  import tinyodin_pkg::*;
#(
  parameter int  N     = 256,
  parameter type req_t = obi_pkg::obi_req_t,
  parameter type rsp_t = obi_pkg::obi_resp_t
) (
  input  logic CLK,
  input  logic RST,
  input  req_t tinyODIN_slave_req_i,
  output rsp_t tinyODIN_slave_resp_o
);

  localparam logic [7:0] LAST = 8'(N - 1);

  logic [31:0] spike_mem [SPIKE_WORDS];
  logic [31:0] neur_mem  [NEURON_WORDS];
  logic [31:0] syn_mem   [SYN_WORDS];

  state_t      state;
  logic [7:0]  t_cnt;
  logic [7:0]  t_max;
  logic [7:0]  p_idx;
  logic [7:0]  q_idx;
  logic [31:0] syn_word;
  logic        busy;
  logic        done;
  logic        rvalid_q;
  logic [31:0] rdata_q;

  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  region;
  logic        gnt;
  logic        bus_wr;
  logic        ctrl_wr;
  logic        start_req;
  logic [31:0] rd_word;

  assign req    = tinyODIN_slave_req_i.req;
  assign we     = tinyODIN_slave_req_i.we;
  assign addr   = tinyODIN_slave_req_i.addr;
  assign wdata  = tinyODIN_slave_req_i.wdata;
  assign region = addr[REGION_LSB +: REGION_W];

  // Memories are locked away from the bus for the whole run, so FSM and bus never collide.
  assign gnt       = req && !RST && !(busy && region != REGION_CTRL);
  assign bus_wr    = gnt && we;
  assign ctrl_wr   = bus_wr && region == REGION_CTRL;
  assign start_req = ctrl_wr && wdata[CTRL_START_BIT] && !busy;

  logic [31:0]     neur_cur;
  logic [V_W-1:0]  v_cur;
  logic [TH_W-1:0] th_cur;
  logic            f_cur;
  logic [7:0]      spike_p;
  logic [7:0]      spike_q;
  logic [W_W-1:0]  weight;
  logic [V_W-1:0]  v_next;
  logic            above;
  logic            fire_now;
  logic            neur_we;
  logic [31:0]     neur_wdata;
  logic            spike_we;

  assign neur_cur = neur_mem[q_idx];
  assign v_cur    = neur_cur[V_LSB +: V_W];
  assign th_cur   = neur_cur[TH_LSB +: TH_W];
  assign f_cur    = neur_cur[F_BIT];
  assign spike_p  = spike_byte(spike_mem[p_idx[7:2]], p_idx[1:0]);
  assign spike_q  = spike_byte(spike_mem[q_idx[7:2]], q_idx[1:0]);
  assign weight   = (state == FIRE) ? '0 : syn_word[{q_idx[2:0], 2'b00} +: W_W];

  tinyodin_neuron_update u_update (
    .v      (v_cur),
    .weight (weight),
    .th     (th_cur),
    .v_next (v_next),
    .above  (above)
  );

  assign fire_now   = (state == FIRE) && !f_cur && above;
  assign neur_we    = !RST && (((state == NEUR_UPD) && !f_cur) || fire_now);
  assign neur_wdata = fire_now ? pack_neuron(v_cur, th_cur, 1'b1)
                               : pack_neuron(v_next, th_cur, f_cur);
  assign spike_we   = !RST && fire_now && (spike_q == SPIKE_NONE);

  always_comb begin
    rd_word = '0;
    case (region)
      REGION_SPIKE:   rd_word = spike_mem[addr[7:2]];
      REGION_NEURON:  rd_word = neur_mem[addr[9:2]];
      REGION_SYNAPSE: rd_word = syn_mem[addr[14:2]];
      default:        rd_word = {t_max, 22'b0, busy, done};
    endcase
  end

  always_ff @(posedge CLK) begin
    if (bus_wr && region == REGION_SPIKE) begin
      spike_mem[addr[7:2]] <= wdata;
    end else if (spike_we) begin
      spike_mem[q_idx[7:2]][{q_idx[1:0], 3'b000} +: 8] <= t_cnt + 8'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (bus_wr && region == REGION_NEURON) begin
      neur_mem[addr[9:2]] <= wdata & NEURON_MASK;
    end else if (neur_we) begin
      neur_mem[q_idx] <= neur_wdata;
    end
  end

  always_ff @(posedge CLK) begin
    if (bus_wr && region == REGION_SYNAPSE) begin
      syn_mem[addr[14:2]] <= wdata;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= gnt;
      rdata_q  <= (gnt && !we) ? rd_word : '0;
    end
  end

  always_comb begin
    tinyODIN_slave_resp_o        = '0;
    tinyODIN_slave_resp_o.gnt    = gnt;
    tinyODIN_slave_resp_o.rvalid = rvalid_q;
    tinyODIN_slave_resp_o.rdata  = rdata_q;
  end

  // One synapse word covers eight post-neurons, so SYN_RD is revisited every eighth q.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      t_cnt    <= '0;
      t_max    <= '0;
      p_idx    <= '0;
      q_idx    <= '0;
      syn_word <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      if (ctrl_wr && !busy) begin
        t_max <= wdata[CTRL_T_LSB +: CTRL_T_W];
      end
      case (state)
        IDLE: begin
          if (start_req) begin
            busy  <= 1'b1;
            done  <= 1'b0;
            t_cnt <= '0;
            p_idx <= '0;
            q_idx <= '0;
            state <= (wdata[CTRL_T_LSB +: CTRL_T_W] == '0) ? DONE : SCAN;
          end
        end
        SCAN: begin
          if (spike_p == t_cnt) begin
            q_idx <= '0;
            state <= SYN_RD;
          end else if (p_idx == LAST) begin
            q_idx <= '0;
            state <= FIRE;
          end else begin
            p_idx <= p_idx + 8'd1;
          end
        end
        SYN_RD: begin
          syn_word <= syn_mem[{p_idx, q_idx[7:3]}];
          state    <= NEUR_UPD;
        end
        NEUR_UPD: begin
          if (q_idx == LAST) begin
            q_idx <= '0;
            if (p_idx == LAST) begin
              state <= FIRE;
            end else begin
              p_idx <= p_idx + 8'd1;
              state <= SCAN;
            end
          end else begin
            q_idx <= q_idx + 8'd1;
            if (q_idx[2:0] == 3'd7) begin
              state <= SYN_RD;
            end
          end
        end
        FIRE: begin
          if (q_idx == LAST) begin
            q_idx <= '0;
            p_idx <= '0;
            t_cnt <= t_cnt + 8'd1;
            state <= (t_cnt + 8'd1 == t_max) ? DONE : SCAN;
          end else begin
            q_idx <= q_idx + 8'd1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{tinyODIN_slave_req_i.be, addr[31:22], addr[19:15], addr[1:0],
                         neur_cur[31:25]};

endmodule

// File: tb/tb_ttfs_tinyodin_charge.sv
// Self-checking bench for ttfs_tinyodin_charge: directed runs plus randomized runs vs. a behavioural model.
// Expected potentials follow TTFS_SATURATE_EN when the bench is built with that macro.
module tb_ttfs_tinyodin_charge;

  localparam logic [31:0] SPIKE_BASE = 32'h0000_0000;
  localparam logic [31:0] NEUR_BASE  = 32'h0010_0000;
  localparam logic [31:0] SYN_BASE   = 32'h0020_0000;
  localparam logic [31:0] CTRL_ADDR  = 32'h0030_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  obi_pkg::obi_req_t  req_s;
  obi_pkg::obi_resp_t rsp_s;

  int tests = 0;
  int failures = 0;

  // Behavioural model state: plain integers per neuron / pre-synaptic input.
  int       pot [256];
  int       thr [256];
  bit       fl  [256];
  int       spk [256];
  bit       used[256];
  logic [3:0] wt [256][256];

  ttfs_tinyodin_charge #(.N(256)) dut (
    .CLK                   (clk),
    .RST                   (rst),
    .tinyODIN_slave_req_i  (req_s),
    .tinyODIN_slave_resp_o (rsp_s)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic busWrite(input logic [31:0] a, input logic [31:0] d, output logic g);
    req_s.req = 1'b1; req_s.we = 1'b1; req_s.be = 4'hF; req_s.addr = a; req_s.wdata = d;
    #1 g = rsp_s.gnt;
    @(negedge clk);
    req_s.req = 1'b0; req_s.we = 1'b0;
  endtask

  task automatic readWord(input logic [31:0] a, output logic [31:0] d, output logic g, output logic v);
    req_s.req = 1'b1; req_s.we = 1'b0; req_s.addr = a;
    #1 g = rsp_s.gnt;
    @(negedge clk);
    v = rsp_s.rvalid;
    d = rsp_s.rdata;
    req_s.req = 1'b0;
  endtask

  function automatic int sext4(input logic [3:0] w);
    return w[3] ? int'(w) - 16 : int'(w);
  endfunction

  function automatic int addV(input int a, input logic [3:0] w);
    int s;
    s = a + sext4(w);
`ifdef TTFS_SATURATE_EN
    if (s > 2047) s = 2047;
    if (s < -2048) s = -2048;
`else
    s = ((s + 2048) & 4095) - 2048;
`endif
    return s;
  endfunction

  function automatic logic [31:0] neurWord(input int q);
    return {7'b0, fl[q], 12'(thr[q]), 12'(pot[q])};
  endfunction

  function automatic logic [31:0] spikeWord(input int w);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = 8'(spk[4*w + b]);
    return r;
  endfunction

  function automatic logic [31:0] synWord(input int p, input int k);
    logic [31:0] r;
    for (int n = 0; n < 8; n++) r[4*n +: 4] = wt[p][8*k + n];
    return r;
  endfunction

  function automatic void clearModel();
    for (int i = 0; i < 256; i++) begin
      pot[i] = 0; thr[i] = 0; fl[i] = 1'b0; spk[i] = 255; used[i] = 1'b0;
      for (int j = 0; j < 256; j++) wt[i][j] = 4'h0;
    end
  endfunction

  // Timestep t: integrate every pre-neuron whose spike time equals t, then fire.
  function automatic void runModel(input int tmax);
    for (int t = 0; t < tmax; t++) begin
      for (int p = 0; p < 256; p++)
        if (spk[p] == t)
          for (int q = 0; q < 256; q++)
            if (!fl[q]) pot[q] = addV(pot[q], wt[p][q]);
      for (int q = 0; q < 256; q++)
        if (!fl[q] && pot[q] >= thr[q]) begin
          fl[q] = 1'b1;
          if (spk[q] == 255) spk[q] = t + 1;
        end
    end
  endfunction

  task automatic loadDut();
    logic g;
    for (int w = 0; w < 64; w++) busWrite(SPIKE_BASE + 32'(w * 4), spikeWord(w), g);
    for (int q = 0; q < 256; q++) busWrite(NEUR_BASE + 32'(q * 4), neurWord(q), g);
    for (int p = 0; p < 256; p++)
      if (used[p])
        for (int k = 0; k < 32; k++) busWrite(SYN_BASE + 32'((p * 32 + k) * 4), synWord(p, k), g);
  endtask

  task automatic waitDone(input string tag);
    logic [31:0] d;
    logic g, v;
    int n = 0;
    do begin
      readWord(CTRL_ADDR, d, g, v);
      n++;
    end while (d[0] !== 1'b1 && n < 20000);
    checkOutput({tag, "_done"}, {31'b0, d[0]}, 32'd1);
  endtask

  task automatic compareAll(input string tag);
    logic [31:0] d;
    logic g, v;
    for (int q = 0; q < 256; q++) begin
      readWord(NEUR_BASE + 32'(q * 4), d, g, v);
      checkOutput($sformatf("%s_neur%0d", tag, q), d, neurWord(q));
    end
    for (int w = 0; w < 64; w++) begin
      readWord(SPIKE_BASE + 32'(w * 4), d, g, v);
      checkOutput($sformatf("%s_spk%0d", tag, w), d, spikeWord(w));
    end
  endtask

  task automatic applyStimulus(input string tag, input logic [7:0] tmax);
    logic g;
    logic [31:0] d;
    logic v;
    loadDut();
    busWrite(CTRL_ADDR, {tmax, 13'b0, 1'b1, 10'b0}, g);
    waitDone(tag);
    readWord(CTRL_ADDR, d, g, v);
    checkOutput({tag, "_ctrl"}, d, {tmax, 24'h000001});
    runModel(int'(tmax));
    compareAll(tag);
  endtask

  initial begin
    logic [31:0] d;
    logic g, v;
    req_s = '0;
    @(negedge clk);

    // Reset: no grant, no response, even with a request pending.
    req_s.req = 1'b1; req_s.addr = NEUR_BASE;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("rst_gnt", {31'b0, rsp_s.gnt}, 32'd0);
      checkOutput("rst_rvalid", {31'b0, rsp_s.rvalid}, 32'd0);
      checkOutput("rst_rdata", rsp_s.rdata, 32'd0);
      @(negedge clk);
    end
    req_s.req = 1'b0;
    rst = 1'b0;
    readWord(CTRL_ADDR, d, g, v);
    checkOutput("rst_ctrl", d, 32'd0);

    // Plain bus write and read-back with the response one cycle after the grant.
    busWrite(NEUR_BASE + 32'd20, 32'h0015E000, g);
    checkOutput("bus_wr_gnt", {31'b0, g}, 32'd1);
    checkOutput("bus_wr_rvalid", {31'b0, rsp_s.rvalid}, 32'd1);
    checkOutput("bus_wr_rdata", rsp_s.rdata, 32'd0);
    readWord(NEUR_BASE + 32'd20, d, g, v);
    checkOutput("bus_rd_gnt", {31'b0, g}, 32'd1);
    checkOutput("bus_rd_rvalid", {31'b0, v}, 32'd1);
    checkOutput("bus_rd_data", d, 32'h0015E000);
    @(negedge clk);
    checkOutput("bus_rvalid_pulse", {31'b0, rsp_s.rvalid}, 32'd0);

    // Single input, no firing.
    clearModel();
    for (int q = 0; q < 256; q++) begin thr[q] = 350; wt[0][q] = 4'h7; end
    spk[0] = 0; used[0] = 1'b1;
    applyStimulus("single", 8'd3);
    readWord(NEUR_BASE, d, g, v);
    checkOutput("single_v0", d, 32'h0015E007);

    // Every neuron crosses a low threshold.
    clearModel();
    for (int q = 0; q < 256; q++) begin thr[q] = 5; wt[0][q] = 4'h7; end
    spk[0] = 0; used[0] = 1'b1;
    applyStimulus("fire", 8'd1);
    readWord(NEUR_BASE + 32'd12, d, g, v);
    checkOutput("fire_n3", d, 32'h01005007);
    readWord(SPIKE_BASE, d, g, v);
    checkOutput("fire_spk0", d, 32'h01010100);

    // Two-hop chain 0 -> 200 -> 250.
    clearModel();
    for (int q = 0; q < 256; q++) thr[q] = 5;
    spk[0] = 0; wt[0][200] = 4'h7; wt[200][250] = 4'h7;
    used[0] = 1'b1; used[200] = 1'b1; used[250] = 1'b1;
    applyStimulus("chain", 8'd3);
    readWord(SPIKE_BASE + 32'd200, d, g, v);
    checkOutput("chain_spk200", d, 32'hFFFFFF01);
    readWord(SPIKE_BASE + 32'd248, d, g, v);
    checkOutput("chain_spk250", d, 32'hFF02FFFF);

    // Negative weight at the bottom of the potential range.
    clearModel();
    for (int q = 0; q < 256; q++) begin thr[q] = 4095; pot[q] = -2048; wt[0][q] = 4'hF; end
    spk[0] = 0; used[0] = 1'b1;
    applyStimulus("neg", 8'd1);
    readWord(NEUR_BASE + 32'd36, d, g, v);
`ifdef TTFS_SATURATE_EN
    checkOutput("neg_n9", d, 32'h00FFF800);
`else
    checkOutput("neg_n9", d, 32'h00FFF7FF);
`endif

    // Bus behaviour while a run is in progress.
    clearModel();
    for (int q = 0; q < 256; q++) begin thr[q] = 5; wt[0][q] = 4'h7; end
    spk[0] = 0; used[0] = 1'b1;
    loadDut();
    busWrite(CTRL_ADDR, 32'h0100_0400, g);
    busWrite(NEUR_BASE + 32'd20, 32'h0012_3456, g);
    checkOutput("busy_neur_gnt", {31'b0, g}, 32'd0);
    readWord(CTRL_ADDR, d, g, v);
    checkOutput("busy_ctrl", d, 32'h0100_0002);
    busWrite(CTRL_ADDR, 32'h0500_0400, g);
    checkOutput("busy_ctrl_gnt", {31'b0, g}, 32'd1);
    waitDone("busy");
    readWord(CTRL_ADDR, d, g, v);
    checkOutput("busy_ctrl_after", d, 32'h0100_0001);
    runModel(1);
    compareAll("busy");

    // T=0: immediate DONE, memories untouched.
    busWrite(CTRL_ADDR, 32'h0000_0400, g);
    @(negedge clk);
    readWord(CTRL_ADDR, d, g, v);
    checkOutput("t0_ctrl", d, 32'h0000_0001);
    compareAll("t0");

    // Reset in the middle of a run aborts it.
    busWrite(CTRL_ADDR, 32'h0300_0400, g);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    readWord(CTRL_ADDR, d, g, v);
    checkOutput("abort_ctrl", d, 32'd0);

    // Randomized single-timestep runs.
    for (int r = 0; r < 3; r++) begin
      clearModel();
      for (int q = 0; q < 256; q++) begin
        thr[q] = int'($urandom_range(0, 40));
        pot[q] = int'($urandom_range(0, 40)) - 20;
        fl[q]  = ($urandom_range(0, 7) == 0);
        spk[q] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 254)) : 255;
      end
      for (int i = 0; i < 8; i++) begin
        int p;
        p = int'($urandom_range(0, 255));
        spk[p] = 0;
        used[p] = 1'b1;
        for (int q = 0; q < 256; q++) wt[p][q] = 4'($urandom);
      end
      applyStimulus($sformatf("rand%0d", r), 8'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
